// File: rtl/h264buf_pkg.sv
// Shared types and layout constants for the macroblock coefficient buffer.
// A slot holds one MB: luma at 0..255, chroma DC at 256..263, chroma AC at 264..383.
package h264buf_pkg;

  typedef enum logic [1:0] {IDLE, LUMA, CDC, CAC} ophase_t;

  localparam int LUMA_N   = 256;
  localparam int CDC_BASE = 256;
  localparam int CAC_BASE = 264;
  localparam int MB_N_420 = 384;

  function automatic logic [8:0] off(input ophase_t phase, input logic [3:0] blk,
                                     input logic [3:0] i);
    logic [8:0] b9;
    logic [8:0] i9;
    b9 = {5'd0, blk};
    i9 = {5'd0, i};
    case (phase)
      CDC:     off = 9'(CDC_BASE) + (b9 << 2) + i9;
      CAC:     off = 9'(CAC_BASE) + (b9 << 4) - b9 + i9;
      default: off = (b9 << 4) + i9;
    endcase
  endfunction

endpackage

// File: rtl/h264buf_ram.sv
// Simple dual-port coefficient store with an enabled, clearable read register.
module h264buf_ram #(
  parameter int CW = 12,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register only moves on a read, so the output holds between reads.
  always_ff @(posedge CLK) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/h264buffer_mb.sv
// Multi-slot MB coefficient buffer: raster writes from the quantiser, block-ordered
// reads toward CAVLC with the neighbour-count handshake.
module h264buffer_mb
  import h264buf_pkg::*;
#(
  parameter int CW     = 12,
  parameter int NSLOT  = 2,
  parameter int CHROMA = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          NEWSLICE,
  input  logic          NEWLINE,
  input  logic          VALIDI,
  input  logic [CW-1:0] ZIN,
  output logic          READYI,
  output logic          CCIN,
  output logic          DONE,
  output logic          ERR,
  output logic [CW-1:0] VOUT,
  output logic          VALIDO,
  output logic          NLOAD,
  output logic [2:0]    NX,
  output logic [2:0]    NY,
  output logic [1:0]    NV,
  output logic          NXINC,
  input  logic          READYO,
  input  logic          TREADYO,
  input  logic          HVALID
);

  localparam int SW = $clog2(NSLOT);
  localparam int AW = SW + 9;
  localparam logic [8:0] MB_LAST = (CHROMA != 0) ? 9'(MB_N_420 - 1) : 9'(LUMA_N - 1);

  logic [SW-1:0] wslot, rslot;
  logic [3:0]    fill;
  logic [8:0]    woff;
  ophase_t       ostate, onext;
  logic [3:0]    oblk, ocnt;
  logic [3:0]    len_m1, nblk_m1;
  logic          nlvalid, ntvalid, cc1;
  logic          accept, in_last, start_ok, issue, blk_end, phase_end, mb_done, nb_done;
  logic          clr;

  assign clr     = !RSTN || NEWSLICE;
  assign READYI  = fill < 4'(NSLOT);
  assign accept  = VALIDI && READYI && !NEWSLICE;
  assign in_last = (woff == MB_LAST);
  assign DONE    = (fill == 4'd0) && (woff == 9'd0) && (ostate == IDLE) && READYO;

  always_comb begin
    len_m1  = 4'd0;
    nblk_m1 = 4'd0;
    onext   = IDLE;
    case (ostate)
      LUMA: begin len_m1 = 4'd15; nblk_m1 = 4'd15; onext = (CHROMA != 0) ? CDC : IDLE; end
      CDC:  begin len_m1 = 4'd3;  nblk_m1 = 4'd1;  onext = CAC;  end
      CAC:  begin len_m1 = 4'd14; nblk_m1 = 4'd7;  onext = IDLE; end
      default: ;
    endcase
  end

  // Starting a block needs the whole downstream ready; mid-block only the header freezes us.
  assign start_ok  = (fill != 4'd0) && !HVALID && READYO && TREADYO;
  assign issue     = (ostate != IDLE) && ((ocnt == 4'd0) ? start_ok : !HVALID);
  assign blk_end   = (ocnt == len_m1);
  assign phase_end = blk_end && (oblk == nblk_m1);
  assign mb_done   = issue && phase_end && (onext == IDLE);
  assign nb_done   = issue && blk_end && ((ostate == LUMA) || (ostate == CAC));

  h264buf_ram #(.CW(CW), .AW(AW)) u_ram (
    .CLK   (CLK),
    .clr   (clr),
    .we    (accept),
    .waddr ({wslot, woff}),
    .wdata (ZIN),
    .re    (issue),
    .raddr ({rslot, off(ostate, oblk, ocnt)}),
    .rdata (VOUT)
  );

  always_ff @(posedge CLK) begin
    if (clr) begin
      wslot   <= '0;
      rslot   <= '0;
      fill    <= 4'd0;
      woff    <= 9'd0;
      ostate  <= IDLE;
      oblk    <= 4'd0;
      ocnt    <= 4'd0;
      nlvalid <= 1'b0;
      ntvalid <= 1'b0;
      cc1     <= 1'b0;
      CCIN    <= 1'b0;
      VALIDO  <= 1'b0;
      NLOAD   <= 1'b0;
      NXINC   <= 1'b0;
      NX      <= 3'd0;
      NY      <= 3'd0;
      NV      <= 2'd0;
      if (!RSTN) ERR <= 1'b0;
    end else begin
      if (VALIDI && !READYI) ERR <= 1'b1;
      if (accept) begin
        woff <= in_last ? 9'd0 : woff + 9'd1;
        if (in_last) wslot <= wslot + SW'(1);
      end
      fill   <= fill + 4'(accept && in_last) - 4'(mb_done);
      cc1    <= accept && woff[8];
      CCIN   <= cc1;
      VALIDO <= issue;
      NLOAD  <= nb_done;
      NXINC  <= mb_done;
      if (mb_done) rslot <= rslot + SW'(1);
      // A new row has no left neighbour even if an MB finished this cycle.
      if (NEWLINE) begin
        nlvalid <= 1'b0;
        ntvalid <= 1'b1;
      end else if (mb_done) begin
        nlvalid <= 1'b1;
      end
      if (ostate == IDLE) begin
        if (fill != 4'd0) ostate <= LUMA;
      end else if (issue) begin
        if (!blk_end) begin
          ocnt <= ocnt + 4'd1;
        end else begin
          ocnt <= 4'd0;
          if (!phase_end) begin
            oblk <= oblk + 4'd1;
          end else begin
            oblk   <= 4'd0;
            ostate <= onext;
          end
        end
      end
      if (issue && (ocnt == 4'd0)) begin
        if (ostate == LUMA) begin
          NX <= {1'b0, oblk[2], oblk[0]};
          NY <= {1'b0, oblk[3], oblk[1]};
        end else if (ostate == CAC) begin
          NX <= {1'b1, oblk[2], oblk[0]};
          NY <= {1'b1, oblk[2], oblk[1]};
        end
      end
      NV <= {ntvalid | NY[0], nlvalid | NX[0]};
    end
  end

endmodule

// File: tb/tb_h264buffer_mb.sv
// Bench for h264buffer_mb: a 4:2:0 instance and a monochrome instance on shared inputs.
module tb_h264buffer_mb;
  localparam int CW = 12;

  logic CLK, RSTN, NEWSLICE, NEWLINE, VALIDI, READYO, TREADYO, HVALID;
  logic [CW-1:0] ZIN;

  logic READYI, CCIN, DONE, ERR, VALIDO, NLOAD, NXINC;
  logic [CW-1:0] VOUT;
  logic [2:0] NX, NY;
  logic [1:0] NV;

  logic m_READYI, m_CCIN, m_DONE, m_ERR, m_VALIDO, m_NLOAD, m_NXINC;
  logic [CW-1:0] m_VOUT;
  logic [2:0] m_NX, m_NY;
  logic [1:0] m_NV;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] m_exp_q[$];
  logic [1:0] nv_log[$];
  logic [5:0] nxy_log[$];
  int nload_cnt, nxinc_cnt, ccin_cnt, m_nload_cnt, m_nxinc_cnt, m_ccin_cnt;
  bit mono_en = 0;
  logic [CW-1:0] mon_exp, m_mon_exp;

  h264buffer_mb #(.CW(CW), .NSLOT(2), .CHROMA(1)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE), .VALIDI(VALIDI),
    .ZIN(ZIN), .READYI(READYI), .CCIN(CCIN), .DONE(DONE), .ERR(ERR), .VOUT(VOUT),
    .VALIDO(VALIDO), .NLOAD(NLOAD), .NX(NX), .NY(NY), .NV(NV), .NXINC(NXINC),
    .READYO(READYO), .TREADYO(TREADYO), .HVALID(HVALID)
  );

  h264buffer_mb #(.CW(CW), .NSLOT(2), .CHROMA(0)) u_mono (
    .CLK(CLK), .RSTN(RSTN), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE), .VALIDI(VALIDI),
    .ZIN(ZIN), .READYI(m_READYI), .CCIN(m_CCIN), .DONE(m_DONE), .ERR(m_ERR), .VOUT(m_VOUT),
    .VALIDO(m_VALIDO), .NLOAD(m_NLOAD), .NX(m_NX), .NY(m_NY), .NV(m_NV), .NXINC(m_NXINC),
    .READYO(READYO), .TREADYO(TREADYO), .HVALID(HVALID)
  );

  // clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard / monitor
  always @(negedge CLK) begin
    if (VALIDO) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vout_extra: got %0d with nothing expected", VOUT);
      end else begin
        mon_exp = exp_q.pop_front();
        if (VOUT !== mon_exp) begin
          errors++;
          $display("FAIL vout: got %0d expected %0d", VOUT, mon_exp);
        end
      end
    end
    if (NLOAD) begin
      nload_cnt++;
      nv_log.push_back(NV);
      nxy_log.push_back({NX, NY});
    end
    if (NXINC) nxinc_cnt++;
    if (CCIN) ccin_cnt++;
    if (mono_en) begin
      if (m_VALIDO) begin
        checks++;
        if (m_exp_q.size() == 0) begin
          errors++;
          $display("FAIL mono_vout_extra: got %0d with nothing expected", m_VOUT);
        end else begin
          m_mon_exp = m_exp_q.pop_front();
          if (m_VOUT !== m_mon_exp) begin
            errors++;
            $display("FAIL mono_vout: got %0d expected %0d", m_VOUT, m_mon_exp);
          end
        end
      end
      if (m_NLOAD) m_nload_cnt++;
      if (m_NXINC) m_nxinc_cnt++;
      if (m_CCIN) m_ccin_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_counts();
    nload_cnt = 0; nxinc_cnt = 0; ccin_cnt = 0;
    m_nload_cnt = 0; m_nxinc_cnt = 0; m_ccin_cnt = 0;
    nv_log.delete();
    nxy_log.delete();
  endtask

  task automatic send_mb(input int tag, input int n, input bit mono);
    for (int i = 0; i < n; i++) begin
      VALIDI = 1'b1;
      ZIN = CW'(tag * 512 + i);
      if (mono) m_exp_q.push_back(ZIN);
      else exp_q.push_back(ZIN);
      tick();
    end
    VALIDI = 1'b0;
  endtask

  task automatic pulse_reset();
    RSTN = 1'b0;
    tick();
    tick();
    RSTN = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget, input bit mono);
    int n;
    n = 0;
    while (((mono ? m_exp_q.size() : exp_q.size()) != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if ((mono ? m_exp_q.size() : exp_q.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs still pending after %0d cycles", name,
               mono ? m_exp_q.size() : exp_q.size(), budget);
      exp_q.delete();
      m_exp_q.delete();
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    tick();
    tick();
    checks++; if (READYI !== 1'b1) begin errors++; $display("FAIL reset_readyi: got %b expected 1", READYI); end
    checks++; if (VALIDO !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", VALIDO); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL reset_done: got %b expected 1", DONE); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", ERR); end
    checks++; if (VOUT !== '0) begin errors++; $display("FAIL reset_vout: got %0d expected 0", VOUT); end
    checks++; if ({NLOAD, NXINC, CCIN, NV} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {NLOAD, NXINC, CCIN, NV});
    end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_order();
    clear_counts();
    send_mb(0, 384, 1'b0);
    wait_drain("order", 600, 1'b0);
    checks++; if (nload_cnt != 24) begin errors++; $display("FAIL order_nload: got %0d expected 24", nload_cnt); end
    checks++; if (nxinc_cnt != 1) begin errors++; $display("FAIL order_nxinc: got %0d expected 1", nxinc_cnt); end
    checks++; if (ccin_cnt != 128) begin errors++; $display("FAIL order_ccin: got %0d expected 128", ccin_cnt); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL order_done: got %b expected 1", DONE); end
    checks++;
    if (nv_log.size() < 1 || nv_log[0] !== 2'b00) begin
      errors++; $display("FAIL order_nv0: got %b expected 00", nv_log.size() ? nv_log[0] : 2'bxx);
    end
    checks++;
    if (nxy_log.size() < 24 || nxy_log[5] !== {3'd3, 3'd0}) begin
      errors++; $display("FAIL order_nxy_luma5: got %b expected 011000", nxy_log.size() > 5 ? nxy_log[5] : 6'bx);
    end
    checks++;
    if (nxy_log.size() < 24 || nxy_log[22] !== {3'd6, 3'd7}) begin
      errors++; $display("FAIL order_nxy_cac6: got %b expected 110111", nxy_log.size() > 22 ? nxy_log[22] : 6'bx);
    end
  endtask

  task automatic test_reset_mid_mb();
    send_mb(1, 100, 1'b0);
    RSTN = 1'b0;
    tick();
    tick();
    checks++; if (READYI !== 1'b1) begin errors++; $display("FAIL midrst_readyi: got %b expected 1", READYI); end
    checks++; if (VALIDO !== 1'b0) begin errors++; $display("FAIL midrst_valido: got %b expected 0", VALIDO); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b expected 1", DONE); end
    exp_q.delete();
    RSTN = 1'b1;
    tick();
    clear_counts();
    send_mb(2, 384, 1'b0);
    wait_drain("midrst", 600, 1'b0);
    checks++; if (nxinc_cnt != 1) begin errors++; $display("FAIL midrst_nxinc: got %0d expected 1", nxinc_cnt); end
  endtask

  task automatic test_hvalid();
    bit found, seen;
    int gap;
    found = 0;
    send_mb(3, 384, 1'b0);
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge CLK);
      if (VALIDO && VOUT == CW'(3 * 512 + 6)) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL hvalid_sync: coefficient 6 not seen expected within 100 cycles"); end
    HVALID = 1'b1;
    gap = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge CLK);
      #1;
      if (k == 4) HVALID = 1'b0;
      @(negedge CLK);
      if (VALIDO) seen = 1;
      else gap++;
    end
    HVALID = 1'b0;
    checks++; if (gap != 5) begin errors++; $display("FAIL hvalid_gap: got %0d expected 5", gap); end
    tick();
    wait_drain("hvalid", 600, 1'b0);
  endtask

  task automatic test_overflow();
    READYO = 1'b0;
    send_mb(4, 384, 1'b0);
    checks++; if (READYI !== 1'b1) begin errors++; $display("FAIL ovf_ready1: got %b expected 1", READYI); end
    send_mb(5, 384, 1'b0);
    checks++; if (READYI !== 1'b0) begin errors++; $display("FAIL ovf_full: got %b expected 0", READYI); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ovf_err_pre: got %b expected 0", ERR); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL ovf_done: got %b expected 0", DONE); end
    VALIDI = 1'b1;
    ZIN = CW'(6 * 512);
    tick();
    VALIDI = 1'b0;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", ERR); end
    READYO = 1'b1;
    wait_drain("ovf", 1500, 1'b0);
    checks++; if (READYI !== 1'b1) begin errors++; $display("FAIL ovf_ready_after: got %b expected 1", READYI); end
    NEWSLICE = 1'b1;
    tick();
    NEWSLICE = 1'b0;
    checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky: got %b expected 1", ERR); end
    checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL ovf_newslice_done: got %b expected 1", DONE); end
    pulse_reset();
    checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL ovf_err_cleared: got %b expected 0", ERR); end
  endtask

  task automatic test_neighbour();
    pulse_reset();
    NEWLINE = 1'b1;
    tick();
    NEWLINE = 1'b0;
    clear_counts();
    send_mb(6, 384, 1'b0);
    send_mb(7, 384, 1'b0);
    wait_drain("nbr", 1200, 1'b0);
    checks++; if (nv_log.size() != 48) begin errors++; $display("FAIL nbr_count: got %0d expected 48", nv_log.size()); end
    checks++; if (nxinc_cnt != 2) begin errors++; $display("FAIL nbr_nxinc: got %0d expected 2", nxinc_cnt); end
    if (nv_log.size() == 48) begin
      checks++; if (nv_log[0] !== 2'b10) begin errors++; $display("FAIL nbr_mb0_blk0: got %b expected 10", nv_log[0]); end
      checks++; if (nv_log[1] !== 2'b11) begin errors++; $display("FAIL nbr_mb0_blk1: got %b expected 11", nv_log[1]); end
      checks++; if (nv_log[2] !== 2'b10) begin errors++; $display("FAIL nbr_mb0_blk2: got %b expected 10", nv_log[2]); end
      checks++; if (nv_log[24] !== 2'b11) begin errors++; $display("FAIL nbr_mb1_blk0: got %b expected 11", nv_log[24]); end
    end
  endtask

  task automatic test_mono();
    pulse_reset();
    clear_counts();
    mono_en = 1;
    send_mb(1, 256, 1'b1);
    wait_drain("mono", 600, 1'b1);
    checks++; if (m_nxinc_cnt != 1) begin errors++; $display("FAIL mono_nxinc: got %0d expected 1", m_nxinc_cnt); end
    checks++; if (m_nload_cnt != 16) begin errors++; $display("FAIL mono_nload: got %0d expected 16", m_nload_cnt); end
    checks++; if (m_ccin_cnt != 0) begin errors++; $display("FAIL mono_ccin: got %0d expected 0", m_ccin_cnt); end
    checks++; if (m_DONE !== 1'b1) begin errors++; $display("FAIL mono_done: got %b expected 1", m_DONE); end
    checks++; if (m_READYI !== 1'b1) begin errors++; $display("FAIL mono_readyi: got %b expected 1", m_READYI); end
    mono_en = 0;
  endtask

  initial begin
    RSTN = 1'b0; NEWSLICE = 1'b0; NEWLINE = 1'b0; VALIDI = 1'b0; ZIN = '0;
    READYO = 1'b1; TREADYO = 1'b1; HVALID = 1'b0;
    clear_counts();
    test_reset();
    test_order();
    test_reset_mid_mb();
    test_hvalid();
    test_overflow();
    test_neighbour();
    test_mono();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
